// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bus between two requesters and alu_arbiter
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*OP_WIDTH-1:0]   req_op;
  logic [2*DATA_WIDTH-1:0] req_in_1;
  logic [2*DATA_WIDTH-1:0] req_in_2;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_result;
  logic                    rsp_bcond;
  logic                    rsp_err;

  modport master (
    output req_valid, req_op, req_in_1, req_in_2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_bcond, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_in_1, req_in_2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_bcond, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Optional illegal-op checking: define ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_arbiter_if.slave          bus,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_in_1_o,
  output logic [DATA_WIDTH-1:0] alu_in_2_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_bcond_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  grant;
  logic [OP_WIDTH-1:0]   cap_op;
  logic [DATA_WIDTH-1:0] cap_in_1;
  logic [DATA_WIDTH-1:0] cap_in_2;
  logic [1:0]            rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_bcond_q;

  logic                  any_valid;
  logic                  win;
  logic [OP_WIDTH-1:0]   sel_op;
  logic [DATA_WIDTH-1:0] sel_in_1;
  logic [DATA_WIDTH-1:0] sel_in_2;

  assign any_valid = |bus.req_valid;
  // On a tie the requester that was not served last wins.
  assign win       = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
  assign sel_op    = win ? bus.req_op[OP_WIDTH +: OP_WIDTH]       : bus.req_op[0 +: OP_WIDTH];
  assign sel_in_1  = win ? bus.req_in_1[DATA_WIDTH +: DATA_WIDTH] : bus.req_in_1[0 +: DATA_WIDTH];
  assign sel_in_2  = win ? bus.req_in_2[DATA_WIDTH +: DATA_WIDTH] : bus.req_in_2[0 +: DATA_WIDTH];

  always_comb begin
    bus.req_ready = 2'b00;
    if (reset_n && state == IDLE && any_valid)
      bus.req_ready = win ? 2'b10 : 2'b01;
  end

  assign alu_op_o       = (state == EXEC) ? cap_op   : '0;
  assign alu_in_1_o     = (state == EXEC) ? cap_in_1 : '0;
  assign alu_in_2_o     = (state == EXEC) ? cap_in_2 : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_bcond  = rsp_bcond_q;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q;
  logic sel_illegal;
  assign sel_illegal = sel_op > OP_WIDTH'(5'b10110);
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      cap_op       <= '0;
      cap_in_1     <= '0;
      cap_in_2     <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_bcond_q  <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            cap_op   <= sel_op;
            cap_in_1 <= sel_in_1;
            cap_in_2 <= sel_in_2;
            grant    <= win;
`ifdef ALU_ARB_OPCHECK_EN
            // Illegal ops never reach the ALU; answer straight from IDLE.
            if (sel_illegal) begin
              state        <= RESP;
              rsp_valid_q  <= win ? 2'b10 : 2'b01;
              rsp_result_q <= '0;
              rsp_bcond_q  <= 1'b0;
              rsp_err_q    <= 1'b1;
            end else begin
              state     <= EXEC;
              rsp_err_q <= 1'b0;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result_i;
          rsp_bcond_q  <= alu_bcond_i;
          rsp_valid_q  <= grant ? 2'b10 : 2'b01;
          state        <= RESP;
        end
        RESP: begin
          // Fairness advances only once the response is actually taken.
          if (bus.rsp_ready[grant]) begin
            rsp_valid_q <= 2'b00;
            last_grant  <= grant;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed, table-driven bench for alu_arbiter with a reference ALU
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2, alu_result;
  logic        alu_bcond;
  int          errors = 0;
  int          checks = 0;

  alu_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(5)) bus ();

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .alu_op_o     (alu_op),
    .alu_in_1_o   (alu_in_1),
    .alu_in_2_o   (alu_in_2),
    .alu_result_i (alu_result),
    .alu_bcond_i  (alu_bcond)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU stand-in: add, sub, xor and four signed branch compares.
  always_comb begin
    alu_result = 32'h0;
    alu_bcond  = 1'b0;
    case (alu_op)
      5'b00011: alu_result = alu_in_1 + alu_in_2;
      5'b00100: alu_result = alu_in_1 - alu_in_2;
      5'b01101: alu_result = alu_in_1 ^ alu_in_2;
      5'b10011: alu_bcond  = (alu_in_1 == alu_in_2);
      5'b10100: alu_bcond  = (alu_in_1 != alu_in_2);
      5'b10101: alu_bcond  = ($signed(alu_in_1) <  $signed(alu_in_2));
      5'b10110: alu_bcond  = ($signed(alu_in_1) >= $signed(alu_in_2));
      default: ;
    endcase
  end

  typedef struct {
    int          r;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        bc;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[r*5 +: 5]     = op;
    bus.req_in_1[r*32 +: 32] = a;
    bus.req_in_2[r*32 +: 32] = b;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [1:0] oh;
    v  = vt[i];
    oh = (v.r == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(v.r, v.op, v.a, v.b);
    bus.req_valid = oh;
    #1 check($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(oh));
    @(negedge clk);
    bus.req_valid = 2'b00;
    set_req(v.r, 5'b00000, 32'hDEAD_BEEF, 32'h1234_5678);
    #1;
    check($sformatf("v%0d_exec_op", i), 64'(alu_op), 64'(v.op));
    check($sformatf("v%0d_exec_in1", i), 64'(alu_in_1), 64'(v.a));
    check($sformatf("v%0d_exec_in2", i), 64'(alu_in_2), 64'(v.b));
    check($sformatf("v%0d_exec_rsp_valid", i), 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'(oh));
    check($sformatf("v%0d_rsp_result", i), 64'(bus.rsp_result), 64'(v.res));
    check($sformatf("v%0d_rsp_bcond", i), 64'(bus.rsp_bcond), 64'(v.bc));
    check($sformatf("v%0d_rsp_err", i), 64'(bus.rsp_err), 64'd0);
    bus.rsp_ready = oh;
    @(negedge clk);
    check($sformatf("v%0d_rsp_cleared", i), 64'(bus.rsp_valid), 64'd0);
    check($sformatf("v%0d_idle_alu_op", i), 64'(alu_op), 64'd0);
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int overlap;
    int early;

    vt[0] = '{0, 5'b00011, 32'd5,         32'd7,  32'd12, 1'b0};
    vt[1] = '{1, 5'b00100, 32'd10,        32'd3,  32'd7,  1'b0};
    vt[2] = '{0, 5'b01101, 32'hF0,        32'hFF, 32'h0F, 1'b0};
    vt[3] = '{1, 5'b10011, 32'd9,         32'd9,  32'd0,  1'b1};
    vt[4] = '{0, 5'b10100, 32'd9,         32'd9,  32'd0,  1'b0};
    vt[5] = '{1, 5'b10110, 32'd3,         32'd5,  32'd0,  1'b0};
    vt[6] = '{0, 5'b10101, 32'hFFFF_FFFF, 32'd1,  32'd0,  1'b1};
    vt[7] = '{0, 5'b00011, 32'hFFFF_FFFF, 32'd1,  32'd0,  1'b0};

    reset_n       = 1'b0;
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    bus.req_op    = '0;
    bus.req_in_1  = '0;
    bus.req_in_2  = '0;
    set_req(0, 5'b00011, 32'd1, 32'd2);
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_rsp_bcond", 64'(bus.rsp_bcond), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_alu_in1", 64'(alu_in_1), 64'd0);

    // Tie right after reset: requester 0 first, then requester 1.
    @(negedge clk);
    reset_n = 1'b1;
    set_req(0, 5'b00100, 32'd10, 32'd3);
    set_req(1, 5'b01101, 32'hF0, 32'hFF);
    bus.req_valid = 2'b11;
    #1 check("tie_first_ready", 64'(bus.req_ready), 64'b01);
    @(negedge clk);
    check("tie_exec_op", 64'(alu_op), 64'b00100);
    check("tie_exec_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("tie_r0_valid", 64'(bus.rsp_valid), 64'b01);
    check("tie_r0_result", 64'(bus.rsp_result), 64'd7);
    check("tie_resp_ready", 64'(bus.req_ready), 64'd0);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("tie_r0_cleared", 64'(bus.rsp_valid), 64'd0);
    check("tie_second_ready", 64'(bus.req_ready), 64'b10);
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("tie_r1_valid", 64'(bus.rsp_valid), 64'b10);
    check("tie_r1_result", 64'(bus.rsp_result), 64'h0F);
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    check("tie_r1_cleared", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 2'b00;

    // Both continuously valid: grants must alternate and responses never overlap.
    set_req(0, 5'b00011, 32'd1, 32'd1);
    set_req(1, 5'b00011, 32'd2, 32'd2);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    overlap = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (bus.req_ready != 2'b00) grants.push_back(int'(bus.req_ready[1]));
      if (bus.rsp_valid == 2'b11) overlap++;
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    bus.rsp_ready = 2'b00;
    check("rr_grant_count_ge4", 64'(grants.size() >= 4), 64'd1);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      check($sformatf("rr_grant%0d", g), 64'(grants[g]), 64'(g % 2));
    check("rr_no_overlap", 64'(overlap), 64'd0);

    // BLT from requester 1 with a stalled consumer.
    @(negedge clk);
    set_req(1, 5'b10101, 32'd3, 32'd5);
    set_req(0, 5'b00011, 32'd4, 32'd4);
    bus.req_valid = 2'b10;
    #1 check("stall_accept", 64'(bus.req_ready), 64'b10);
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), 64'(bus.rsp_valid), 64'b10);
      check($sformatf("stall%0d_bcond", c), 64'(bus.rsp_bcond), 64'd1);
      check($sformatf("stall%0d_result", c), 64'(bus.rsp_result), 64'd0);
      check($sformatf("stall%0d_r0_ready", c), 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    check("stall_cleared", 64'(bus.rsp_valid), 64'd0);
    check("stall_r0_now_ready", 64'(bus.req_ready), 64'b01);
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;

    // Reset pulse while the op is executing.
    set_req(0, 5'b00011, 32'd1, 32'd1);
    bus.req_valid = 2'b01;
    #1 check("rexec_accept", 64'(bus.req_ready), 64'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    check("rexec_in_exec", 64'(alu_op), 64'b00011);
    reset_n = 1'b0;
    #1;
    check("rexec_alu_op", 64'(alu_op), 64'd0);
    check("rexec_alu_in1", 64'(alu_in_1), 64'd0);
    check("rexec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) early++;
    end
    check("rexec_no_response", 64'(early), 64'd0);
    bus.rsp_ready = 2'b00;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Opcode above the branch range.
    @(negedge clk);
    set_req(0, 5'b11111, 32'd6, 32'd6);
    bus.req_valid = 2'b01;
    #1 check("ill_accept", 64'(bus.req_ready), 64'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
    check("ill_alu_op", 64'(alu_op), 64'd0);
    check("ill_valid_c1", 64'(bus.rsp_valid), 64'b01);
    check("ill_err", 64'(bus.rsp_err), 64'd1);
    check("ill_result", 64'(bus.rsp_result), 64'd0);
`else
    check("ill_alu_op", 64'(alu_op), 64'b11111);
    check("ill_valid_c1", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("ill_valid_c2", 64'(bus.rsp_valid), 64'b01);
    check("ill_err", 64'(bus.rsp_err), 64'd0);
    check("ill_result", 64'(bus.rsp_result), 64'd0);
    check("ill_bcond", 64'(bus.rsp_bcond), 64'd0);
`endif
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("ill_cleared", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. the main execute path and an auxiliary address/branch unit.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Sequencing: round-robin grant, operand capture, one-cycle execute on the shared ALU, registered response held until consumed.
- Sits between the requesters and the shared ALU; drives the ALU inputs and samples its result/bcond.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the shared ALU.
- OP_WIDTH, 5, ALU opcode width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  2  bit i: requester i presents an op
- req_ready  output  2  bit i: requester i's op accepted this cycle
- req_op  input  2*OP_WIDTH  requester i op at [i*OP_WIDTH +: OP_WIDTH]
- req_in_1  input  2*DATA_WIDTH  requester i operand 1 at [i*DATA_WIDTH +: DATA_WIDTH]
- req_in_2  input  2*DATA_WIDTH  requester i operand 2, same packing
- rsp_valid  output  2  bit i: response for requester i available
- rsp_ready  input  2  bit i: requester i consumes response
- rsp_result  output  DATA_WIDTH  registered ALU result (shared bus)
- rsp_bcond  output  1  registered ALU branch condition
- rsp_err  output  1  illegal-op flag; constant 0 unless ALU_ARB_OPCHECK_EN
- alu_op_o  output  OP_WIDTH  to shared ALU alu_op
- alu_in_1_o  output  DATA_WIDTH  to shared ALU alu_in_1
- alu_in_2_o  output  DATA_WIDTH  to shared ALU alu_in_2
- alu_result_i  input  DATA_WIDTH  from shared ALU alu_result
- alu_bcond_i  input  1  from shared ALU alu_bcond

Behaviour:
- Reset: clk and reset_n as stated; reset is asynchronous, active-low.
  - While reset_n=0: state=IDLE, rsp_valid=0, req_ready=0, rsp_result=0, rsp_bcond=0, rsp_err=0, captured op/operands=0, alu_*_o=0.
  - While reset_n=0: last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and one-hot, asserted only for the winner.
  - Winner: the sole valid requester; if both are valid, the requester != last_grant.
  - On the accepting edge: capture op, in_1 and in_2 into internal registers; record grant index; go to EXEC.
  - No valid requester: stay in IDLE, req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_op_o, alu_in_1_o and alu_in_2_o are driven from the captured registers.
  - At the closing edge: rsp_result<=alu_result_i, rsp_bcond<=alu_bcond_i, rsp_valid[grant]<=1; go to RESP.
- Outside EXEC, alu_op_o=0 (the ALU's always-0 op) and alu_in_*_o=0.
- RESP:
  - rsp_valid[grant], rsp_result and rsp_bcond are held stable until rsp_ready[grant]=1.
  - On the consuming edge: rsp_valid<=0, last_grant<=grant, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Latency and throughput:
  - Accept in cycle N; rsp_valid high from cycle N+2.
  - Minimum issue interval is 3 cycles; there is no pipelining of requests.
- req_ready=0 in EXEC and RESP. Requesters must hold valid and operands until accepted; operand changes after acceptance have no effect.
- Ops 10011..10110 (BEQ/BNE/BLT/BGE) return result 0 with bcond from the ALU. All other ops return bcond 0.
- rsp_valid is never asserted for more than one requester.
- last_grant updates only on response consumption, so a requester stalled in RESP does not lose fairness.
- Reset mid-EXEC or mid-RESP: the in-flight op is discarded with no response, and state returns to IDLE.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - At acceptance, an op > 5'b10110 is marked illegal.
  - An illegal op skips EXEC (IDLE->RESP directly) and the ALU stays at op 0.
  - Its response carries rsp_result=0, rsp_bcond=0, rsp_err=1.
  - Legal ops return rsp_err=0.
- Undefined:
  - All ops go through EXEC and return whatever the ALU produces (0/0 for undefined codes).
  - rsp_err is tied to 0.

Test Plan:
- Requester 0 only, op=00011, in_1=5, in_2=7, rsp_ready=1 -> req_ready[0] in cycle 0; rsp_valid[0] in cycle 2 with rsp_result=12, rsp_bcond=0; IDLE in cycle 3.
- Both valid at the first cycle after reset: r0 op=00100 (10,3), r1 op=01101 (0xF0,0xFF) -> r0 served first with result 7; r1 accepted next with result 0x0F.
- Both requesters continuously valid for 4 ops -> grant order 0,1,0,1; no rsp_valid overlap.
- r1 op=10101 (BLT) with in_1=3, in_2=5, rsp_ready low for 3 cycles -> rsp_valid[1] and rsp_bcond=1 held stable with result 0; cleared one edge after rsp_ready=1; req_ready[0] stays 0 throughout.
- reset_n pulsed low during EXEC of op=00011 (1,1) -> all outputs 0 immediately; no response ever issued; next request served normally.
- With ALU_ARB_OPCHECK_EN: op=11111 -> alu_op_o stays 0; rsp_valid in cycle 1 with rsp_err=1, rsp_result=0. Without the macro: rsp_valid in cycle 2, rsp_err=0.
